// File: rtl/seq_mult_nbit.sv
// Unsigned NxN shift-add multiplier with start/busy/done handshake.
// One add-or-skip plus right shift per cycle; the product is ready after N iterations.
module seq_mult_nbit #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_acc_hi;
    logic [N-1:0]  r_acc_lo;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          w_load;
    logic          w_step;
    logic [N-1:0]  w_addend;
    logic [N:0]    w_add;

    // Ripple-carry add with carry-in 0; result is {carry_out, sum}.
    function automatic logic [N:0] ripple_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] res;
        logic       c;
        res = '0;
        c   = 1'b0;
        for (int k = 0; k < N; k++) begin
            res[k] = x[k] ^ y[k] ^ c;
            c      = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        res[N] = c;
        return res;
    endfunction

    // Partial-product add: multiplicand only when the current multiplier bit is set.
    always_comb begin
        w_addend = '0;
        if (r_acc_lo[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = '0;
        end
        w_add = ripple_add(r_acc_hi, w_addend);
    end

    // Next-state logic and datapath load/step controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Accumulator: load operands on accept, add-and-shift while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc_hi <= w_add[N:1];
            r_acc_lo <= {w_add[0], r_acc_lo[N-1:1]};
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_mcand  <= r_mcand;
            r_acc_hi <= r_acc_hi;
            r_acc_lo <= r_acc_lo;
            r_cnt    <= r_cnt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Self-checking bench for seq_mult_nbit: directed cases on N=4 and N=8 plus
// randomized operands compared against plain a*b and the handshake timing.
module tb_seq_mult_nbit;

    logic        clk;
    logic        rst_n;
    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  prod4;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    int n_checks;
    int n_fail;

    seq_mult_nbit #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mult_nbit #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full N=4 operation: N busy cycles, single done pulse with a*b, then hold.
    task automatic mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] exp;
        exp = {4'd0, x} * {4'd0, y};
        @(negedge clk);
        a4 = x; b4 = y; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            check_val("busy4_run", busy4, 1);
            check_val("done4_run", done4, 0);
            @(negedge clk);
        end
        check_val("done4_pulse", done4, 1);
        check_val("busy4_done", busy4, 0);
        check_val("prod4", prod4, exp);
        @(negedge clk);
        check_val("done4_after", done4, 0);
        check_val("busy4_after", busy4, 0);
        check_val("prod4_hold", prod4, exp);
    endtask

    task automatic mul8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] exp;
        exp = {8'd0, x} * {8'd0, y};
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            check_val("busy8_run", busy8, 1);
            check_val("done8_run", done8, 0);
            @(negedge clk);
        end
        check_val("done8_pulse", done8, 1);
        check_val("busy8_done", busy8, 0);
        check_val("prod8", prod8, exp);
        @(negedge clk);
        check_val("done8_after", done8, 0);
        check_val("prod8_hold", prod8, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start4   = 1'b0; a4 = 4'd0; b4 = 4'd0;
        start8   = 1'b0; a8 = 8'd0; b8 = 8'd0;

        // Reset asserted mid-cycle, then idle with start low.
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy4, 0);
        check_val("rst_done", done4, 0);
        check_val("rst_prod", prod4, 0);
        check_val("rst_prod8", prod8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("idle_out", {busy4, done4, prod4}, 0);
        end

        // Basic, then product holds while idle.
        mul4(4'd5, 4'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold15", {busy4, done4, prod4}, 32'h0F);
        end

        // Max carry and zero operands.
        mul4(4'd15, 4'd15);
        mul8(8'd255, 8'd255);
        mul4(4'd0, 4'd9);
        mul4(4'd7, 4'd0);

        // Start pulsed during RUN cycle 2 is ignored.
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check_val("ign_busy1", busy4, 1);
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
        check_val("ign_busy2", busy4, 1);
        @(negedge clk);
        start4 = 1'b0;
        check_val("ign_busy3", busy4, 1);
        @(negedge clk);
        check_val("ign_busy4", busy4, 1);
        check_val("ign_nodone", done4, 0);
        @(negedge clk);
        check_val("ign_done", done4, 1);
        check_val("ign_prod", prod4, 42);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("ign_quiet", {busy4, done4, prod4}, 42);
        end

        // Back-to-back with start held high: 12 then 81, five cycles apart.
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; start4 = 1'b1;
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd9;
        for (int i = 0; i < 4; i++) begin
            check_val("b2b_busy1", busy4, 1);
            @(negedge clk);
        end
        check_val("b2b_done1", done4, 1);
        check_val("b2b_prod1", prod4, 12);
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("b2b_busy2", busy4, 1);
            check_val("b2b_nodone", done4, 0);
            @(negedge clk);
        end
        check_val("b2b_done2", done4, 1);
        check_val("b2b_prod2", prod4, 81);
        @(negedge clk);
        check_val("b2b_idle", {busy4, done4}, 0);

        // Reset during RUN aborts; no done follows.
        a4 = 4'd11; b4 = 4'd13; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy4, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_rst", {busy4, done4, prod4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("abort_quiet", {busy4, done4, prod4}, 0);
        end
        mul4(4'd11, 4'd13);

        // Randomized operands on both widths.
        for (int i = 0; i < 12; i++) begin
            mul4(4'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            mul8(8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
